// File: rtl/isq_issue_picker.sv
// Issue-queue dequeue picker: selects the oldest ready entry relative to the ROB head,
// strobes its clear line and holds its payload in a one-deep valid/ready output register.
module isq_issue_picker #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned DATA_WIDTH  = 248,
  parameter int unsigned INDEX_WIDTH = 4,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [DEPTH-1:0]              entry_ready,
  input  logic [DEPTH*DATA_WIDTH-1:0]   entry_data,
  input  logic [DEPTH*INDEX_WIDTH-1:0]  entry_index,
  input  logic [INDEX_WIDTH-1:0]        rob_head,
  input  logic                          flush,
  output logic [DEPTH-1:0]              entry_clear,
  output logic                          issue_valid,
  output logic [DATA_WIDTH-1:0]         issue_data,
  output logic [INDEX_WIDTH-1:0]        issue_index,
  input  logic                          issue_ready,
  output logic [CNT_WIDTH-1:0]          issued_count
);

  localparam int unsigned SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [INDEX_WIDTH-1:0] index_q, index_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

  logic                   found;
  logic [INDEX_WIDTH-1:0] age;
  logic [INDEX_WIDTH-1:0] best_age;
  logic [SEL_W-1:0]       win;
  logic [DATA_WIDTH-1:0]  win_data;
  logic [INDEX_WIDTH-1:0] win_index;
  logic                   can_accept;
  logic                   pick;
  logic                   handshake;

  // Oldest-first scan; strict less-than keeps the lowest slot on equal age.
  always_comb begin
    found     = 1'b0;
    age       = '0;
    best_age  = '0;
    win       = '0;
    win_data  = '0;
    win_index = '0;
    for (int k = 0; k < DEPTH; k++) begin
      age = INDEX_WIDTH'(entry_index[k*INDEX_WIDTH +: INDEX_WIDTH] - rob_head);
      if (entry_ready[k] && (!found || (age < best_age))) begin
        found     = 1'b1;
        best_age  = age;
        win       = SEL_W'(k);
        win_data  = entry_data[k*DATA_WIDTH +: DATA_WIDTH];
        win_index = entry_index[k*INDEX_WIDTH +: INDEX_WIDTH];
      end
    end
  end

  assign issue_valid  = (state_q == FULL);
  assign can_accept   = !issue_valid || issue_ready;
  assign pick         = can_accept && (|entry_ready) && !flush;
  assign handshake    = issue_valid && issue_ready;
  assign entry_clear  = (pick && reset_n) ? (DEPTH'(1) << win) : '0;
  assign issue_data   = data_q;
  assign issue_index  = index_q;
  assign issued_count = cnt_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    index_d = index_q;
    cnt_d   = cnt_q;
    if (handshake) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
    if (flush) begin
      state_d = EMPTY;
    end else if (pick) begin
      state_d = FULL;
      data_d  = win_data;
      index_d = win_index;
    end else if (handshake) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      index_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      index_q <= index_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_isq_issue_picker.sv
// Directed + random bench for isq_issue_picker with a payload scoreboard and a small
// reference model of pick/valid/count behaviour.
module tb_isq_issue_picker;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned DW    = 248;
  localparam int unsigned IW    = 4;
  localparam int unsigned CW    = 4;

  logic                  clock = 1'b0;
  logic                  reset_n;
  logic [DEPTH-1:0]      entry_ready;
  logic [DEPTH*DW-1:0]   entry_data;
  logic [DEPTH*IW-1:0]   entry_index;
  logic [IW-1:0]         rob_head;
  logic                  flush;
  logic [DEPTH-1:0]      entry_clear;
  logic                  issue_valid;
  logic [DW-1:0]         issue_data;
  logic [IW-1:0]         issue_index;
  logic                  issue_ready;
  logic [CW-1:0]         issued_count;

  isq_issue_picker #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .INDEX_WIDTH(IW), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset_n(reset_n), .entry_ready(entry_ready), .entry_data(entry_data),
    .entry_index(entry_index), .rob_head(rob_head), .flush(flush), .entry_clear(entry_clear),
    .issue_valid(issue_valid), .issue_data(issue_data), .issue_index(issue_index),
    .issue_ready(issue_ready), .issued_count(issued_count)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int errors  = 0;

  logic          rdy [DEPTH];
  logic [IW-1:0] idx [DEPTH];
  logic [DW-1:0] dat [DEPTH];

  logic          m_valid;
  logic [CW-1:0] m_count;
  logic [DW-1:0] q_data [$];
  logic [IW-1:0] q_idx  [$];

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [255:0] t;
    for (int j = 0; j < 8; j++) t[j*32 +: 32] = $urandom();
    return DW'(t);
  endfunction

  task automatic set_entry(input int k, input logic [IW-1:0] i);
    rdy[k] = 1'b1;
    idx[k] = i;
    dat[k] = rnd_data();
  endtask

  task automatic drive();
    for (int k = 0; k < DEPTH; k++) begin
      entry_ready[k]             = rdy[k];
      entry_index[k*IW +: IW]    = idx[k];
      entry_data[k*DW +: DW]     = dat[k];
    end
  endtask

  // One clock cycle: check the combinational clear, then the registered outputs after the edge.
  task automatic step(input string tag);
    logic          can_acc, any, pk, hs, found;
    logic [IW-1:0] age, best;
    int            w;
    logic [DEPTH-1:0] exp_clr;
    drive();
    @(negedge clock);
    can_acc = !m_valid || issue_ready;
    any = 1'b0;
    for (int k = 0; k < DEPTH; k++) any |= rdy[k];
    pk = can_acc && any && !flush;
    hs = m_valid && issue_ready;
    found = 1'b0; best = '0; w = 0;
    for (int k = 0; k < DEPTH; k++) begin
      age = IW'(idx[k] - rob_head);
      if (rdy[k] && (!found || age < best)) begin found = 1'b1; best = age; w = k; end
    end
    exp_clr = pk ? (DEPTH'(1) << w) : '0;
    chk({tag, ".clear"}, DW'(entry_clear), DW'(exp_clr));
    if (hs) begin
      if (q_data.size() > 0) begin
        chk({tag, ".hs_data"}, issue_data, q_data.pop_front());
        chk({tag, ".hs_index"}, DW'(issue_index), DW'(q_idx.pop_front()));
      end
    end else if (flush && m_valid && q_data.size() > 0) begin
      void'(q_data.pop_front());
      void'(q_idx.pop_front());
    end
    @(posedge clock);
    #1;
    if (hs) m_count = m_count + CW'(1);
    if (flush) m_valid = 1'b0;
    else if (pk) begin
      m_valid = 1'b1;
      q_data.push_back(dat[w]);
      q_idx.push_back(idx[w]);
      rdy[w] = 1'b0;
    end else if (hs) m_valid = 1'b0;
    chk({tag, ".valid"}, DW'(issue_valid), DW'(m_valid));
    chk({tag, ".count"}, DW'(issued_count), DW'(m_count));
    if (m_valid && q_data.size() > 0) begin
      chk({tag, ".data"}, issue_data, q_data[0]);
      chk({tag, ".index"}, DW'(issue_index), DW'(q_idx[0]));
    end
  endtask

  task automatic clear_entries();
    for (int k = 0; k < DEPTH; k++) begin rdy[k] = 1'b0; idx[k] = '0; dat[k] = '0; end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_count = '0;
    q_data.delete();
    q_idx.delete();
  endtask

  initial begin
    logic [DW-1:0] held;
    clear_entries();
    model_reset();
    rob_head = '0; flush = 1'b0; issue_ready = 1'b0;
    reset_n = 1'b0;
    set_entry(0, 4'd1);
    drive();
    #12;
    // Reset state, including clear suppressed while an entry is ready.
    chk("rst.valid", DW'(issue_valid), '0);
    chk("rst.data",  issue_data, '0);
    chk("rst.index", DW'(issue_index), '0);
    chk("rst.count", DW'(issued_count), '0);
    chk("rst.clear", DW'(entry_clear), '0);
    clear_entries();
    drive();
    @(posedge clock); #1;
    reset_n = 1'b1;

    // Single issue: entry 3, index 5.
    issue_ready = 1'b1;
    set_entry(3, 4'd5);
    step("single.t");
    chk("single.idx5", DW'(issue_index), DW'(4'd5));
    step("single.t1");
    chk("single.cnt1", DW'(issued_count), DW'(4'd1));

    // Age with wrap around the ROB head.
    rob_head = 4'd14;
    set_entry(0, 4'd2); set_entry(1, 4'd15); set_entry(2, 4'd14);
    step("wrap.a");
    chk("wrap.first", DW'(issue_index), DW'(4'd14));
    step("wrap.b");
    chk("wrap.second", DW'(issue_index), DW'(4'd15));
    step("wrap.c");
    chk("wrap.third", DW'(issue_index), DW'(4'd2));
    step("wrap.drain");

    // Backpressure: clear stays low and payload holds.
    rob_head = 4'd0;
    issue_ready = 1'b0;
    set_entry(4, 4'd3); set_entry(5, 4'd6);
    step("bp.fill");
    held = issue_data;
    for (int c = 0; c < 4; c++) begin
      step("bp.stall");
      chk("bp.stable", issue_data, held);
    end
    issue_ready = 1'b1;
    step("bp.release");
    step("bp.drain");

    // Tie on equal age picks the lower slot first.
    set_entry(6, 4'd7); set_entry(2, 4'd7);
    step("tie.a");
    chk("tie.first", DW'(issue_data), DW'(dat[2]));
    step("tie.b");
    step("tie.drain");

    // Flush while stalled with entries ready.
    issue_ready = 1'b0;
    set_entry(1, 4'd9); set_entry(7, 4'd10);
    step("fl.fill");
    flush = 1'b1;
    step("fl.flush");
    flush = 1'b0;
    chk("fl.cnt_hold", DW'(issued_count), DW'(m_count));
    // Flush coincident with a completing handshake still counts it.
    step("fl.refill");
    issue_ready = 1'b1; flush = 1'b1;
    step("fl.hs_flush");
    flush = 1'b0;
    step("fl.after");

    // Randomised mix.
    for (int r = 0; r < 40; r++) begin
      for (int k = 0; k < DEPTH; k++) if (!rdy[k] && ($urandom_range(0, 2) == 0)) set_entry(k, IW'($urandom()));
      rob_head    = IW'($urandom());
      issue_ready = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 7) == 0);
      step("rand");
    end
    flush = 1'b0;

    // Asynchronous reset mid-transfer.
    issue_ready = 1'b0;
    set_entry(3, 4'd1);
    step("ar.fill");
    clear_entries();
    drive();
    reset_n = 1'b0;
    #1;
    chk("ar.valid", DW'(issue_valid), '0);
    chk("ar.data",  issue_data, '0);
    chk("ar.index", DW'(issue_index), '0);
    chk("ar.count", DW'(issued_count), '0);
    chk("ar.clear", DW'(entry_clear), '0);
    model_reset();
    #1;
    reset_n = 1'b1;

    // Counter wrap: 17 handshakes on a 4-bit counter.
    issue_ready = 1'b1;
    for (int n = 0; n < 18; n++) begin
      set_entry(n % DEPTH, IW'(n));
      step("cw");
    end
    chk("cw.wrap", DW'(issued_count), DW'(4'd1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/isq_issue_picker.md
# isq_issue_picker

Dequeue-side reader for an issue-queue bank of condition-tracked entries. Each cycle it scans the per-entry ready flags (valid and all condition bits set), selects the oldest ready entry relative to the ROB head, and pulses that entry's clear line. It captures the entry's payload into a one-deep output register and presents it to the functional unit over a valid/ready handshake. It sits between the entry array and the execution-unit dispatch port.

## Interface
- DEPTH, 8, number of entries scanned (≥2)
- DATA_WIDTH, 248, payload width per entry
- INDEX_WIDTH, 4, ROB index width; age compare is modulo 2^INDEX_WIDTH
- CNT_WIDTH, 16, width of issued-instruction counter

- clock  input  1  clock
- reset_n  input  1  reset, asynchronous, active-low
- entry_ready  input  DEPTH  per-entry ready_to_dequeue
- entry_data  input  DEPTH*DATA_WIDTH  packed payloads; entry k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- entry_index  input  DEPTH*INDEX_WIDTH  packed ROB indices; same packing
- rob_head  input  INDEX_WIDTH  current oldest ROB index
- flush  input  1  pipeline flush
- entry_clear  output  DEPTH  one-hot (or zero) clear strobe to entries
- issue_valid  output  1  output register holds an instruction
- issue_data  output  DATA_WIDTH  issued payload
- issue_index  output  INDEX_WIDTH  issued ROB index
- issue_ready  input  1  FU accepts this cycle
- issued_count  output  CNT_WIDTH  count of completed handshakes

## Operation
- Age of entry k: age_k = (index_k − rob_head) mod 2^INDEX_WIDTH (INDEX_WIDTH-bit unsigned subtract, wrap discarded). Smaller age = older.
- Candidate set: entry_ready[k]=1. Winner: minimum age. Tie on equal age: lowest k.
- can_accept = !issue_valid || issue_ready.
- pick = can_accept && |entry_ready && !flush.
- entry_clear = onehot(winner) when pick, else 0. Combinational in the same cycle. Forced 0 while reset_n low.
- On a clock edge with pick: issue_valid←1; issue_data/issue_index←winner's payload/index.
- On an edge with issue_valid && issue_ready && !pick: issue_valid←0; data/index hold.
- On an edge with flush: issue_valid←0; a handshake completing in the same cycle is still counted.
- issued_count increments by 1 on each edge where issue_valid && issue_ready. Wraps at 2^CNT_WIDTH.
- issue_data/issue_index hold while issue_valid && !issue_ready. They must not change under backpressure.
- No internal FSM beyond the single valid bit: EMPTY (issue_valid=0) / FULL (issue_valid=1).
  - EMPTY→FULL on pick.
  - FULL→FULL on handshake+pick or on stall.
  - FULL→EMPTY on handshake without pick, or on flush.

## Timing
- Reset values: issue_valid=0, issue_data=0, issue_index=0, issued_count=0, entry_clear=0.
- Latency: an entry ready in cycle t with can_accept gets entry_clear[k]=1 in cycle t and issue_valid=1 in cycle t+1.
- Throughput: one issue per cycle with issue_ready held high.
- The entry drops its ready at the t→t+1 edge, so the same entry is never picked twice.
- Backpressure: with issue_valid=1 and issue_ready=0, entry_clear stays 0 and no entry is consumed.
- Flush and pick in the same cycle: flush wins. No clear is pulsed and issue_valid goes 0.
- Asynchronous reset mid-transfer: outputs go to reset values immediately. A pending instruction is dropped.
- rob_head may change every cycle. Age is evaluated with the current-cycle value only.

## Test plan
- Single issue: reset, then entry 3 ready with index 5, rob_head=0, issue_ready=1 → entry_clear=8'b0000_1000 in cycle t; issue_valid=1 and issue_index=5 at t+1; issued_count=1 at t+2.
- Age with wrap: rob_head=14; entries 0/1/2 ready with indices 2/15/14 → picks entry 2 (age 0), then entry 1, then entry 0 on consecutive cycles.
- Backpressure: hold issue_ready=0 for 4 cycles with issue_valid=1 and other entries ready → entry_clear=0 and issue_data stable throughout. Releasing issue_ready gives the handshake and the next pick in the same cycle.
- Tie: entries 2 and 6 both index 7 → entry 2 chosen first.
- Flush: issue_valid=1, issue_ready=0, flush=1 with entries ready → next cycle issue_valid=0, entry_clear=0 during the flush cycle, issued_count unchanged.
- Counter wrap / reset: CNT_WIDTH=4, run 17 handshakes → issued_count=1. Assert reset_n low mid-stream → all outputs 0 asynchronously.
